// File: rtl/m_mc_pkg.sv
// m_mc_pkg -- shared definitions for the multi-cycle controller.
// Holds the controller state encoding (also reported on w_state), the
// RV32 opcode constants the controller dispatches on, the ALU operand /
// ALU operation / result-bus select encodings, and the opcode dispatch
// helper used in DECODE.
package m_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_AUIPC  = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUREG    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALUDIRECT = 2'b10;

  // State entered from DECODE for a given opcode; anything unknown traps.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_R:              return S_EXECR;
      OP_I:              return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/m_mc_branch_eval.sv
// m_mc_branch_eval -- conditional branch decision.
// Ports:
//   funct3   in  3  branch kind from the instruction register
//   alu_zero in  1  rs1 - rs2 == 0
//   take     out 1  branch is taken (only BEQ and BNE are supported;
//                   every other funct3 falls through)
module m_mc_branch_eval
  import m_mc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (funct3)
      F3_BEQ:  take = alu_zero;
      F3_BNE:  take = !alu_zero;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/m_mc_controller.sv
// m_mc_controller -- control FSM of a multi-cycle RV32 core with one
// unified memory port.
// Ports:
//   w_clk, w_rst (async, active high)
//   w_opcode, w_funct3, w_alu_zero       decode / datapath status
//   w_mem_ready                          memory finishes access this cycle
//   w_mem_req, w_mem_we, w_adr_src       memory request side
//   w_ir_write, w_pc_write, w_reg_write  datapath write enables
//   w_alu_src_a, w_alu_src_b, w_alu_op   ALU steering
//   w_result_src                         result bus select
//   w_state                              current state code (state_t)
//   w_illegal                            sticky unsupported-opcode flag
//   w_cycles, w_retired                  performance counters, present
//                                        only when M_MC_CTRL_PERF_EN is
//                                        defined
// Memory handshake: w_mem_req (with w_mem_we and w_adr_src) is raised by
// the state and held unchanged until the cycle in which w_mem_ready is 1;
// that cycle completes the access and the state advances on the next edge.
// A request is never withdrawn early except by reset.
module m_mc_controller
  import m_mc_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [6:0]        w_opcode,
  input  logic [2:0]        w_funct3,
  input  logic              w_alu_zero,
  input  logic              w_mem_ready,
  output logic              w_mem_req,
  output logic              w_mem_we,
  output logic              w_adr_src,
  output logic              w_ir_write,
  output logic              w_pc_write,
  output logic              w_reg_write,
  output logic [1:0]        w_alu_src_a,
  output logic [1:0]        w_alu_src_b,
  output logic [1:0]        w_alu_op,
  output logic [1:0]        w_result_src,
  output logic [3:0]        w_state,
`ifdef M_MC_CTRL_PERF_EN
  output logic [PERF_W-1:0] w_cycles,
  output logic [PERF_W-1:0] w_retired,
`endif
  output logic              w_illegal
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  state_t state, state_next;
  logic   branch_take;

  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

  m_mc_branch_eval u_branch_eval (
    .funct3   (w_funct3),
    .alu_zero (w_alu_zero),
    .take     (branch_take)
  );

  // State register
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (w_mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = dispatch(w_opcode);
      S_MEMADR: state_next = (w_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (w_mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (w_mem_ready) state_next = S_FETCH;
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC:
        state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  // Output decode: a function of state only, except the ready-qualified
  // fetch pulses and the branch-taken PC write.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUREG;
    case (state)
      S_FETCH: begin
        // PC + 4 goes straight from the ALU onto the result bus.
        mem_req    = 1'b1;
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUDIRECT;
      end
      S_DECODE: begin
        // Branch/JAL target (old PC + imm) is captured in the ALU register.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEMDATA;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUREG;
      end
      S_BRANCH: begin
        // Compare rs1 - rs2; the taken target is already in the ALU register.
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        pc_write   = branch_take;
        result_src = RES_ALUREG;
      end
      S_JAL: begin
        // Target from the ALU register; rd receives old PC + 4 from the
        // datapath link path in the same cycle.
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_ALUREG;
      end
      S_JALR: begin
        // Target rs1 + imm computed this cycle; the datapath clears bit 0.
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_ALUDIRECT;
      end
      S_LUI: begin
        reg_write  = 1'b1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALUDIRECT;
      end
      S_AUIPC: begin
        // old PC + imm was captured in DECODE.
        reg_write  = 1'b1;
        result_src = RES_ALUREG;
      end
      default: ;
    endcase
  end

  // Reset forces every enable low immediately, abandoning any access.
  assign w_mem_req    = mem_req   & ~w_rst;
  assign w_mem_we     = mem_we    & ~w_rst;
  assign w_ir_write   = ir_write  & ~w_rst;
  assign w_pc_write   = pc_write  & ~w_rst;
  assign w_reg_write  = reg_write & ~w_rst;
  assign w_adr_src    = adr_src;
  assign w_alu_src_a  = alu_src_a;
  assign w_alu_src_b  = alu_src_b;
  assign w_alu_op     = alu_op;
  assign w_result_src = result_src;
  assign w_state      = state;
  // TRAP is absorbing, so the flag stays set until reset.
  assign w_illegal    = (state == S_TRAP);

`ifdef M_MC_CTRL_PERF_EN
  logic [PERF_W-1:0] cycles_q, retired_q;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      if (state != S_TRAP) cycles_q <= cycles_q + PERF_W'(1);
      // An instruction retires when control returns to FETCH.
      if (state != S_FETCH && state_next == S_FETCH)
        retired_q <= retired_q + PERF_W'(1);
    end
  end

  assign w_cycles  = cycles_q;
  assign w_retired = retired_q;
`endif

endmodule

// File: tb/tb_m_mc_controller.sv
// tb_m_mc_controller -- self-checking bench for m_mc_controller.
// Define M_MC_CTRL_PERF_EN to also check the performance counters.
module tb_m_mc_controller;
  import m_mc_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       w_clk = 1'b0;
  logic       w_rst;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_alu_zero;
  logic       w_mem_ready;
  logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
  logic [3:0] w_state;
  logic       w_illegal;
`ifdef M_MC_CTRL_PERF_EN
  logic [31:0] w_cycles, w_retired;
`endif

  always #5 w_clk = ~w_clk;

  m_mc_controller #(.PERF_W(32)) dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_opcode     (w_opcode),
    .w_funct3     (w_funct3),
    .w_alu_zero   (w_alu_zero),
    .w_mem_ready  (w_mem_ready),
    .w_mem_req    (w_mem_req),
    .w_mem_we     (w_mem_we),
    .w_adr_src    (w_adr_src),
    .w_ir_write   (w_ir_write),
    .w_pc_write   (w_pc_write),
    .w_reg_write  (w_reg_write),
    .w_alu_src_a  (w_alu_src_a),
    .w_alu_src_b  (w_alu_src_b),
    .w_alu_op     (w_alu_op),
    .w_result_src (w_result_src),
    .w_state      (w_state),
`ifdef M_MC_CTRL_PERF_EN
    .w_cycles     (w_cycles),
    .w_retired    (w_retired),
`endif
    .w_illegal    (w_illegal)
  );

  // Bench-local opcode literals, independent of the design package.
  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011,
                         T_R    = 7'b0110011, T_I     = 7'b0010011,
                         T_BR   = 7'b1100011, T_JAL   = 7'b1101111,
                         T_JALR = 7'b1100111, T_LUI   = 7'b0110111,
                         T_AUI  = 7'b0010111;
  logic [6:0] op_tab [9] = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI, T_AUI};

  // ---------------- scoreboard state ----------------
  int total_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] trace_q[$];
  int obs_lat, obs_rw, obs_pw, obs_ir, obs_req, obs_we, obs_unstable, obs_ill, obs_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the recorded state trace with exp_q.
  task automatic check_trace(input string tag);
    check($sformatf("%s_len", tag), 32'(trace_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_st%0d", tag, i),
            (i < trace_q.size()) ? 32'(trace_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge with the DUT in FETCH. Runs one
  // instruction: the fetch access waits fw cycles, a data access mw cycles.
  // Returns at the falling edge where FETCH is re-entered.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic zero,
                           input int fw, input int mw);
    int   wait_left, acc_idx;
    bit   req_active, left_fetch, done;
    logic req_we, req_adr;
    obs_lat = 0; obs_rw = 0; obs_pw = 0; obs_ir = 0; obs_req = 0; obs_we = 0;
    obs_unstable = 0; obs_ill = 0; obs_timeout = 0;
    trace_q.delete();
    wait_left = 0; acc_idx = 0; req_active = 0; left_fetch = 0; done = 0;
    req_we = 1'b0; req_adr = 1'b0;
    w_opcode = op; w_funct3 = f3; w_alu_zero = zero;
    while (!done) begin
      if (w_mem_req === 1'b1 && !req_active) begin
        req_active = 1;
        wait_left  = (acc_idx == 0) ? fw : mw;
        acc_idx++;
        req_we  = w_mem_we;
        req_adr = w_adr_src;
      end
      if (req_active) begin
        w_mem_ready = (wait_left == 0);
        if (wait_left > 0) wait_left--;
      end else begin
        w_mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      trace_q.push_back(w_state);
      obs_lat++;
      obs_rw  += int'(w_reg_write);
      obs_pw  += int'(w_pc_write);
      obs_ir  += int'(w_ir_write);
      obs_req += int'(w_mem_req);
      obs_we  += int'(w_mem_we);
      obs_ill += int'(w_illegal);
      if (w_state != S_FETCH) left_fetch = 1;
      if (req_active && (w_mem_req !== 1'b1 || w_mem_we !== req_we || w_adr_src !== req_adr))
        obs_unstable++;
      if (req_active && w_mem_ready) req_active = 0;
      @(negedge w_clk);
      if (left_fetch && w_state == S_FETCH) done = 1;
      else if (obs_lat >= 200) begin
        obs_timeout = 1;
        done = 1;
      end
    end
  endtask

  // Reference model: expected latency and pulse counts from the
  // instruction class and the memory wait pattern.
  task automatic check_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic zero, input int fw, input int mw);
    bit ld, st, br, jmp, taken;
    int lat, rw, pw, req, we;
    ld  = (op == T_LOAD);
    st  = (op == T_STORE);
    br  = (op == T_BR);
    jmp = (op == T_JAL) || (op == T_JALR);
    taken = br && ((f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero));
    if (ld)                               lat = 5 + mw;
    else if (st)                          lat = 4 + mw;
    else if (op == T_R || op == T_I)      lat = 4;
    else                                  lat = 3; // branch, jumps, LUI, AUIPC
    lat += fw;
    rw  = (st || br) ? 0 : 1;
    pw  = 1 + (jmp ? 1 : 0) + (taken ? 1 : 0);
    req = fw + 1 + ((ld || st) ? mw + 1 : 0);
    we  = st ? mw + 1 : 0;
    check({tag, "_timeout"},  32'(obs_timeout),  0);
    check({tag, "_latency"},  32'(obs_lat),      32'(lat));
    check({tag, "_reg_write"}, 32'(obs_rw),      32'(rw));
    check({tag, "_pc_write"}, 32'(obs_pw),       32'(pw));
    check({tag, "_ir_write"}, 32'(obs_ir),       1);
    check({tag, "_mem_req"},  32'(obs_req),      32'(req));
    check({tag, "_mem_we"},   32'(obs_we),       32'(we));
    check({tag, "_stable"},   32'(obs_unstable), 0);
    check({tag, "_illegal"},  32'(obs_ill),      0);
  endtask

  task automatic do_reset();
    w_rst = 1'b1;
    w_mem_ready = 1'b1;
    repeat (2) @(negedge w_clk);
    #1;
    check("rst_mem_req",   32'(w_mem_req),   0);
    check("rst_ir_write",  32'(w_ir_write),  0);
    check("rst_pc_write",  32'(w_pc_write),  0);
    check("rst_reg_write", 32'(w_reg_write), 0);
    check("rst_state",     32'(w_state),     32'(S_FETCH));
    check("rst_illegal",   32'(w_illegal),   0);
`ifdef M_MC_CTRL_PERF_EN
    check("rst_cycles",  w_cycles,  0);
    check("rst_retired", w_retired, 0);
`endif
    @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check("post_rst_fetch_req", 32'(w_mem_req), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int bad_en, ill_cyc, trap_cyc;
    w_rst = 1'b1; w_opcode = T_I; w_funct3 = 3'b000; w_alu_zero = 1'b0; w_mem_ready = 1'b0;

    do_reset();

    // addi x1,x0,5 with memory always ready, then nine more.
    run_instr(T_I, 3'b000, 1'b0, 0, 0);
    exp_q = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
    check_trace("addi_trace");
    check_instr("addi0", T_I, 3'b000, 1'b0, 0, 0);
    for (int k = 1; k < 10; k++) begin
      run_instr(T_I, 3'b000, 1'b0, 0, 0);
      check_instr($sformatf("addi%0d", k), T_I, 3'b000, 1'b0, 0, 0);
    end
`ifdef M_MC_CTRL_PERF_EN
    #1;
    check("perf_retired_10", w_retired, 10);
    check("perf_cycles_40",  w_cycles,  40);
`endif

    // Unsupported opcode: fetch, decode, then 20 cycles parked in TRAP.
    w_opcode = 7'b0000000;
    bad_en = 0; ill_cyc = 0; trap_cyc = 0;
    for (int c = 0; c < 22; c++) begin
      w_mem_ready = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (c >= 2) begin
        bad_en   += int'(w_mem_req | w_mem_we | w_ir_write | w_pc_write | w_reg_write);
        ill_cyc  += int'(w_illegal);
        trap_cyc += int'(w_state == S_TRAP);
      end
      @(negedge w_clk);
    end
    check("trap_enables", 32'(bad_en),   0);
    check("trap_illegal", 32'(ill_cyc),  20);
    check("trap_state",   32'(trap_cyc), 20);
`ifdef M_MC_CTRL_PERF_EN
    #1;
    check("trap_cycles_frozen", w_cycles,  42);
    check("trap_retired",       w_retired, 10);
`endif
    do_reset();

    // lw with the data access waiting 3 cycles.
    run_instr(T_LOAD, 3'b010, 1'b0, 0, 3);
    exp_q = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
    check_trace("lw_trace");
    check_instr("lw_wait3", T_LOAD, 3'b010, 1'b0, 0, 3);

    // beq taken, then not taken.
    run_instr(T_BR, 3'b000, 1'b1, 0, 0);
    exp_q = '{S_FETCH, S_DECODE, S_BRANCH};
    check_trace("beq_t_trace");
    check_instr("beq_taken", T_BR, 3'b000, 1'b1, 0, 0);
    run_instr(T_BR, 3'b000, 1'b0, 0, 0);
    check_instr("beq_not_taken", T_BR, 3'b000, 1'b0, 0, 0);

    // Reset while a store is waiting in MEMWR.
    w_opcode = T_STORE; w_funct3 = 3'b010;
    for (int c = 0; c < 5; c++) begin
      w_mem_ready = (c == 0) ? 1'b1 : 1'b0;
      #1;
      if (c < 4) @(negedge w_clk);
    end
    check("sw_wait_state", 32'(w_state),   32'(S_MEMWR));
    check("sw_wait_req",   32'(w_mem_req), 1);
    check("sw_wait_we",    32'(w_mem_we),  1);
    #1 w_rst = 1'b1;
    #1;
    check("sw_rst_req",   32'(w_mem_req), 0);
    check("sw_rst_we",    32'(w_mem_we),  0);
    check("sw_rst_state", 32'(w_state),   32'(S_FETCH));
    @(negedge w_clk);
    w_rst = 1'b0;
    #1;
    check("sw_resume_req", 32'(w_mem_req), 1);
    check("sw_resume_we",  32'(w_mem_we),  0);
    run_instr(T_I, 3'b000, 1'b0, 0, 0);
    check_instr("resume_addi", T_I, 3'b000, 1'b0, 0, 0);

    // Random instruction mix with random memory wait states.
    for (int k = 0; k < 60; k++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic       z;
      int         fw, mw;
      op = op_tab[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, f3, z, fw, mw);
      check_instr($sformatf("rnd%0d_op%02h", k, op), op, f3, z, fw, mw);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
